// File: rtl/pe_mac_psum.sv
// -----------------------------------------------------------------------------
// pe_mac_psum
//   Multiply-accumulate front end of a processing element. One job per start
//   pulse: filt_len+1 signed ifmap/weight pairs are multiplied and summed into
//   a wide accumulator. The formatted result goes to the partial-sum
//   scratchpad as a single psum_wr strobe, followed by a one-cycle done pulse.
//
//   Pipeline: the beat accepted at one edge is multiplied into prod_q. It is
//   added to acc_q at the next edge. So after the last beat one DRAIN cycle
//   folds in the final product before EMIT presents the result.
//
//   Optional feature (compile-time macro):
//     PE_MAC_SATURATE_EN  - when defined, psum_data clamps acc to the signed
//                           DATA_W range. When undefined, psum_data is the
//                           low DATA_W bits of acc, which wraps in two's
//                           complement. FSM and timing are the same either way.
// -----------------------------------------------------------------------------
module pe_mac_psum #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4,
   parameter int ACC_W  = 2*DATA_W + LEN_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         filt_len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] ifmap,
   input  logic signed [DATA_W-1:0] weight,
   input  logic                     psum_full,
   output logic                     psum_wr,
   output logic [DATA_W-1:0]        psum_data,
   output logic                     busy,
   output logic                     done
);

   localparam int PROD_W = 2*DATA_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_EMIT  = 2'd3
   } state_t;

   state_t                    state_q;
   logic                      done_q;
   logic [LEN_W-1:0]          len_q;
   logic [LEN_W-1:0]          cnt_q,    cnt_d;
   logic signed [PROD_W-1:0]  prod_q,   prod_d;
   logic                      prod_v_q, prod_v_d;
   logic signed [ACC_W-1:0]   acc_q,    acc_d;
   logic signed [ACC_W-1:0]   prod_ext;

   logic job_start;   // start accepted this cycle (only honoured in IDLE)
   logic beat;        // ifmap/weight pair accepted this cycle
   logic last_beat;   // accepted pair is the final one of the job

   // in_ready depends on state only, so it never waits on in_valid.
   assign in_ready  = (state_q == S_RUN);
   assign busy      = (state_q != S_IDLE);
   assign psum_wr   = (state_q == S_EMIT) && !psum_full;
   assign done      = done_q;

   assign job_start = (state_q == S_IDLE) && start;
   assign beat      = in_valid && in_ready;
   assign last_beat = beat && (cnt_q == len_q);

   // Sign-extend the registered product to accumulator width.
   assign prod_ext  = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

   // Control FSM: sequencing, job length latch and the registered done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments, so every always block
         // in this file sees the values from before the edge, whatever
         // order the blocks run in.
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_q   <= filt_len;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (last_beat) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // The final product is added to acc at this edge.
               state_q <= S_EMIT;
            end
            S_EMIT: begin
               if (!psum_full) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Datapath next state: beat counter, product register and accumulator.
   always_comb begin
      // NOTE: every signal gets a value before any branch, so no path can
      // leave one unassigned and infer a latch.
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      prod_v_d = beat;
      acc_d    = acc_q;

      if (prod_v_q) begin
         acc_d = acc_q + prod_ext;
      end

      if (beat) begin
         prod_d = PROD_W'(ifmap) * PROD_W'(weight);
         cnt_d  = cnt_q + LEN_W'(1);
      end

      // A new job starts from a clean accumulator and counter.
      if (job_start) begin
         acc_d    = '0;
         cnt_d    = '0;
         prod_v_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the datapath registers are reset as well as the control
         // state. An aborted job then leaves no residue, and psum_data
         // reads 0 while reset is held.
         cnt_q    <= '0;
         prod_q   <= '0;
         prod_v_q <= 1'b0;
         acc_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         prod_v_q <= prod_v_d;
         acc_q    <= acc_d;
      end
   end

`ifdef PE_MAC_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   // Output format: clamp the accumulator to the signed DATA_W range.
   always_comb begin
      if (acc_q > SAT_MAX) begin
         psum_data = SAT_MAX[DATA_W-1:0];
      end else if (acc_q < SAT_MIN) begin
         psum_data = SAT_MIN[DATA_W-1:0];
      end else begin
         psum_data = acc_q[DATA_W-1:0];
      end
   end
`else
   // Output format: keep the low DATA_W bits, which wrap in two's complement.
   always_comb begin
      psum_data = acc_q[DATA_W-1:0];
   end
`endif

endmodule
